// File: rtl/shape_point_latch_if.sv
// rtl/shape_point_latch_if.sv - pen point / frame / endpoint bundle for shape_point_latch
//
// Purpose: groups the pen-tracker inputs and the circle-renderer endpoint
// outputs of shape_point_latch into one bundle.
// Signals:
//   x_in [10:0], y_in [9:0]   detected pen coordinate
//   point_valid_in            one-cycle strobe, x_in/y_in valid
//   pen_in                    raw asynchronous pen-down button level
//   new_frame_in              one-cycle frame-start strobe
//   x_out_1/y_out_1           anchor endpoint
//   x_out_2/y_out_2           drag endpoint
//   shape_valid_out           endpoints describe a drawable shape
//   state_out [1:0]           FSM state (IDLE=0, ANCHOR=1, DRAG=2, HOLD=3)
// Modports: master drives the inputs (pen tracker side), slave is the latch.

interface shape_point_latch_if;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic        point_valid_in;
  logic        pen_in;
  logic        new_frame_in;
  logic [10:0] x_out_1;
  logic [9:0]  y_out_1;
  logic [10:0] x_out_2;
  logic [9:0]  y_out_2;
  logic        shape_valid_out;
  logic [1:0]  state_out;

  modport master (
    output x_in, y_in, point_valid_in, pen_in, new_frame_in,
    input  x_out_1, y_out_1, x_out_2, y_out_2, shape_valid_out, state_out
  );

  modport slave (
    input  x_in, y_in, point_valid_in, pen_in, new_frame_in,
    output x_out_1, y_out_1, x_out_2, y_out_2, shape_valid_out, state_out
  );
endinterface

// File: rtl/shape_point_latch.sv
// rtl/shape_point_latch.sv - pen-stroke endpoint latch feeding a circle renderer
//
// Purpose: tracks a pen stroke (pen down, anchor point, drag points, pen up),
// commits the two endpoints when the horizontal span is at least MIN_SPAN and
// presents either the live stroke or the committed shape, updated once per frame.
// Ports:
//   clk_in   system clock, rising edge
//   rst_in   asynchronous active-high reset
//   bus      shape_point_latch_if.slave (point/pen/frame inputs, endpoint outputs)
// Parameters:
//   MIN_SPAN         minimum |x2-x1| in pixels for a commit
//   DEBOUNCE_CYCLES  pen stability window, used only with debounce compiled in
// Build option: define SHAPE_POINT_LATCH_DEBOUNCE_EN to debounce the
// synchronized pen level; otherwise the synchronized level is used directly.

module shape_point_latch #(
  parameter int MIN_SPAN        = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic               clk_in,
  input logic               rst_in,
  shape_point_latch_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ANCHOR = 2'd1;
  localparam logic [1:0] ST_DRAG   = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [11:0] MIN_SPAN_W = 12'(MIN_SPAN);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [1:0]  state;
  logic        pen_s1, pen_s2, pen_lvl, pen_prev;
  logic        pen_rise, pen_fall;
  logic        pt_ok;
  logic [10:0] p1_x, p2_x, c1_x, c2_x;
  logic [9:0]  p1_y, p2_y, c1_y, c2_y;
  logic        committed;
  logic [10:0] p2_x_upd;
  logic [9:0]  p2_y_upd;
  logic signed [11:0] dx;
  logic [11:0] span;
  logic        span_ok;
  logic [10:0] sh_x1, sh_x2;
  logic [9:0]  sh_y1, sh_y2;
  logic        sh_v;

  // Two-flop synchronizer for the asynchronous pen button.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pen_s1 <= 1'b0;
      pen_s2 <= 1'b0;
    end else begin
      pen_s1 <= bus.pen_in;
      pen_s2 <= pen_s1;
    end
  end

`ifdef SHAPE_POINT_LATCH_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            db_lvl;
  logic [DB_W-1:0] db_cnt;

  // Counts consecutive cycles where the synchronized pen disagrees with the
  // accepted level; the level flips on the DEBOUNCE_CYCLES-th such cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      db_lvl <= 1'b0;
      db_cnt <= '0;
    end else if (pen_s2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_lvl <= pen_s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign pen_lvl = db_lvl;
`else
  assign pen_lvl = pen_s2;
`endif

  // pen_prev resets low so a pen held down through reset reads as a rise.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) pen_prev <= 1'b0;
    else        pen_prev <= pen_lvl;
  end

  assign pen_rise = pen_lvl & ~pen_prev;
  assign pen_fall = ~pen_lvl & pen_prev;

  assign pt_ok = bus.point_valid_in && (bus.x_in <= 11'd1279) && (bus.y_in <= 10'd719);

  // Span check uses P2 as it will be after this cycle's point, so a point
  // arriving together with pen-up is included in the decision.
  assign p2_x_upd = pt_ok ? bus.x_in : p2_x;
  assign p2_y_upd = pt_ok ? bus.y_in : p2_y;
  assign dx       = $signed({1'b0, p2_x_upd}) - $signed({1'b0, p1_x});
  assign span     = dx[11] ? $unsigned(-dx) : $unsigned(dx);
  assign span_ok  = (span >= MIN_SPAN_W);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      p1_x      <= '0;
      p1_y      <= '0;
      p2_x      <= '0;
      p2_y      <= '0;
      c1_x      <= '0;
      c1_y      <= '0;
      c2_x      <= '0;
      c2_y      <= '0;
      committed <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pen_rise) state <= ST_ANCHOR;
        end
        ST_ANCHOR: begin
          if (pen_fall) begin
            state <= ST_IDLE;
          end else if (pt_ok) begin
            p1_x  <= bus.x_in;
            p1_y  <= bus.y_in;
            p2_x  <= bus.x_in;
            p2_y  <= bus.y_in;
            state <= ST_DRAG;
          end
        end
        ST_DRAG: begin
          p2_x <= p2_x_upd;
          p2_y <= p2_y_upd;
          if (pen_fall) begin
            if (span_ok) begin
              c1_x      <= p1_x;
              c1_y      <= p1_y;
              c2_x      <= p2_x_upd;
              c2_y      <= p2_y_upd;
              committed <= 1'b1;
              state     <= ST_HOLD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (pen_rise) state <= ST_ANCHOR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Live preview while dragging, committed shape otherwise.
  always_comb begin
    sh_x1 = c1_x;
    sh_y1 = c1_y;
    sh_x2 = c2_x;
    sh_y2 = c2_y;
    sh_v  = committed;
    if (state == ST_DRAG) begin
      sh_x1 = p1_x;
      sh_y1 = p1_y;
      sh_x2 = p2_x;
      sh_y2 = p2_y;
      sh_v  = 1'b1;
    end
  end

  // Outputs only move on the frame strobe so a frame never sees a torn shape.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus.x_out_1         <= '0;
      bus.y_out_1         <= '0;
      bus.x_out_2         <= '0;
      bus.y_out_2         <= '0;
      bus.shape_valid_out <= 1'b0;
    end else if (bus.new_frame_in) begin
      bus.x_out_1         <= sh_x1;
      bus.y_out_1         <= sh_y1;
      bus.x_out_2         <= sh_x2;
      bus.y_out_2         <= sh_y2;
      bus.shape_valid_out <= sh_v;
    end
  end

  assign bus.state_out = state;

endmodule

// File: doc/shape_point_latch.md
SHAPE_POINT_LATCH -- requirements
Module: shape_point_latch

Interface
REQ-001 Parameter MIN_SPAN, default 4: minimum |x2-x1| in pixels for a stroke to be committed.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: pen stability window in clk_in cycles; used only when debounce is compiled in.
REQ-003 clk_in  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous and active-high.
REQ-005 x_in  input  11  detected pen x coordinate.
REQ-006 y_in  input  10  detected pen y coordinate.
REQ-007 point_valid_in  input  1  one-cycle strobe; x_in/y_in are valid.
REQ-008 pen_in  input  1  raw, asynchronous pen-down button level.
REQ-009 new_frame_in  input  1  one-cycle strobe at frame start; output update point.
REQ-010 x_out_1, y_out_1  output  11/10  anchor endpoint to the circle renderer.
REQ-011 x_out_2, y_out_2  output  11/10  drag endpoint to the circle renderer.
REQ-012 shape_valid_out  output  1  endpoints describe a drawable shape.
REQ-013 state_out  output  2  current FSM state (IDLE=0, ANCHOR=1, DRAG=2, HOLD=3).

Function
REQ-014 pen_in shall pass through a 2-flop synchronizer; pen rise/fall events shall be edges of the synchronized (or debounced) level.
REQ-015 Points with x_in>1279 or y_in>719 shall be ignored, as if point_valid_in were 0.
REQ-016 IDLE: on pen rise -> ANCHOR; otherwise remain in IDLE.
REQ-017 ANCHOR: the first accepted point shall load working P1 and P2 with the same (x,y), then -> DRAG; pen fall before any point -> IDLE with no commit.
REQ-018 DRAG: every accepted point shall overwrite working P2; P1 shall be unchanged.
REQ-019 DRAG on pen fall: if |P2.x-P1.x| >= MIN_SPAN, copy P1/P2 into committed registers, set committed flag, -> HOLD; otherwise -> IDLE, leaving prior committed data untouched.
REQ-020 Pen fall and accepted point in the same DRAG cycle: apply the point to P2 first, then run the span check on the updated P2.
REQ-021 HOLD: on pen rise -> ANCHOR; the committed shape shall remain displayed until a new commit.
REQ-022 Shadow selection: in DRAG the shadow shall be the working P1/P2 with valid=1 (live preview); in all other states it shall be the committed registers with valid = committed flag.
REQ-023 Outputs shall update only in a cycle where new_frame_in=1, registering the shadow value present before that cycle's edge, so outputs are constant within a frame.
REQ-024 Endpoints shall be emitted unsorted; abs-difference arithmetic shall be 12-bit signed so that no wrap occurs.
REQ-025 state_out shall reflect the state register combinationally (no extra latency).

Reset
REQ-026 On rst_in=1, asynchronously: state=IDLE, all working and committed registers=0, committed flag=0, synchronizer/debounce state=0, all outputs=0.
REQ-027 Reset asserted mid-stroke shall abandon the stroke; after release, the FSM requires a fresh pen rise (pen held high across reset shall count as a rise once synchronized).

Configuration
REQ-028 With SHAPE_POINT_LATCH_DEBOUNCE_EN defined, the debounced pen level shall change only after the synchronized pen holds its new value for DEBOUNCE_CYCLES consecutive cycles; a shorter glitch shall produce no event.
REQ-029 Without SHAPE_POINT_LATCH_DEBOUNCE_EN, the synchronized level shall be used directly, giving 2-cycle pen event latency, and DEBOUNCE_CYCLES shall be ignored.

Verification
REQ-030 Pen rise, point (100,200), points (140,210) and (160,220), pen fall, then new_frame_in -> outputs (100,200)/(160,220), shape_valid_out=1, state_out=3.
REQ-031 Stroke ending at x=102 from anchor x=100 (MIN_SPAN=4) -> state_out=0, shape_valid_out=0, or the previous committed shape unchanged.
REQ-032 In DRAG, point (300,100) in the same cycle as new_frame_in -> outputs show the P2 value held before that cycle; the next frame strobe shows (300,100).
REQ-033 Point (1300,50) during DRAG -> P2 unchanged at the following frame strobe.
REQ-034 rst_in pulsed during DRAG -> all outputs 0 immediately, state_out=0, and no commit occurs.
REQ-035 With debounce enabled: pen glitch of DEBOUNCE_CYCLES-1 cycles -> state stays IDLE; a pulse of DEBOUNCE_CYCLES cycles -> state goes to ANCHOR.
